// File: rtl/dmem_arbiter.sv
// Two-port req/gnt arbiter and single-access sequencer owning all data_mem inputs.
// Ports: clk, rst_n (sync, active-low); m0_*/m1_* request (req, we, addr, wd)
// and response (gnt, rvalid, rdata, err) channels; mem_we/mem_addr/mem_wd to
// data_mem, mem_rd from data_mem. Build option DMEM_ARB_RR_EN selects
// round-robin contention (default: port 0 fixed priority).
module dmem_arbiter #(
    parameter int CAPACITY = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state;
    logic        cmd_we;
    logic        cmd_port;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wd;
    logic        last_win;

    logic        rv0, rv1;
    logic        er0, er1;
    logic [31:0] rd0, rd1;

    logic        in_access;
    logic        in_range;
    logic        arb_en;
    logic        any_req;
    logic        win;
    logic [31:0] rdata_n;

    assign in_access = (state == S_ACCESS);
    assign in_range  = (cmd_addr < 32'(CAPACITY));
    // Grants are suppressed while reset is low so nothing is accepted
    // that the reset edge would then silently drop.
    assign arb_en    = rst_n && (state == S_IDLE || state == S_RESP);
    assign any_req   = m0_req | m1_req;

`ifdef DMEM_ARB_RR_EN
    assign win = (m0_req && m1_req) ? ~last_win : m1_req;
`else
    assign win = ~m0_req;
`endif

    assign m0_gnt = arb_en & any_req & ~win;
    assign m1_gnt = arb_en & any_req & win;

    // Decoded from state only (not rst_n): a write in ACCESS still commits
    // on a coinciding reset edge.
    assign mem_we   = in_access & cmd_we & in_range;
    assign mem_addr = in_access ? cmd_addr : 32'd0;
    assign mem_wd   = in_access ? cmd_wd : 32'd0;

    assign rdata_n  = (in_range && !cmd_we) ? mem_rd : 32'd0;

    assign m0_rvalid = rv0;
    assign m1_rvalid = rv1;
    assign m0_rdata  = rd0;
    assign m1_rdata  = rd1;
    assign m0_err    = er0;
    assign m1_err    = er1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cmd_we   <= 1'b0;
            cmd_port <= 1'b0;
            cmd_addr <= 32'd0;
            cmd_wd   <= 32'd0;
            last_win <= 1'b1;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
            er0      <= 1'b0;
            er1      <= 1'b0;
            rd0      <= 32'd0;
            rd1      <= 32'd0;
        end else begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
            er0 <= 1'b0;
            er1 <= 1'b0;
            rd0 <= 32'd0;
            rd1 <= 32'd0;
            unique case (state)
                S_ACCESS: begin
                    state <= S_RESP;
                    if (cmd_port) begin
                        rv1 <= 1'b1;
                        rd1 <= rdata_n;
                        er1 <= ~in_range;
                    end else begin
                        rv0 <= 1'b1;
                        rd0 <= rdata_n;
                        er0 <= ~in_range;
                    end
                end
                default: begin
                    // IDLE and RESP arbitrate identically.
                    if (any_req) begin
                        state    <= S_ACCESS;
                        cmd_port <= win;
                        cmd_we   <= win ? m1_we : m0_we;
                        cmd_addr <= win ? m1_addr : m0_addr;
                        cmd_wd   <= win ? m1_wd : m0_wd;
                        last_win <= win;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int          CAP  = 128;
    localparam logic [31:0] CAPW = 32'd128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wd = '0, m1_wd = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] dm [CAP];
    logic [31:0] ref_mem [CAP];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    dmem_arbiter #(.CAPACITY(CAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data_mem stand-in: combinational read, write on the clock edge.
    initial for (int i = 0; i < CAP; i++) begin
        dm[i] = '0;
        ref_mem[i] = '0;
    end
    always @(posedge clk)
        if (mem_we && mem_addr < CAPW) dm[mem_addr[6:0]] <= mem_wd;
    assign mem_rd = (mem_addr < CAPW) ? dm[mem_addr[6:0]] : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a grant is possible only if no grant happened in the
    // previous cycle; a grant at cycle c accesses memory at c+1 and
    // responds at c+2. Reset cancels anything in flight.
    typedef struct packed {
        logic        v;
        logic        p;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
    } txn_t;

    initial begin : model
        txn_t h1, h2, g;
        bit armed, lw, any, w, ok;
        armed = 0;
        lw = 1;
        h1 = '0;
        h2 = '0;
        forever begin
            @(negedge clk);
            #3;
            any = m0_req | m1_req;
`ifdef DMEM_ARB_RR_EN
            w = (m0_req && m1_req) ? !lw : m1_req;
`else
            w = !m0_req;
`endif
            g = '0;
            if (rst_n && !h1.v && any) begin
                g.v  = 1;
                g.p  = w;
                g.we = w ? m1_we : m0_we;
                g.a  = w ? m1_addr : m0_addr;
                g.wd = w ? m1_wd : m0_wd;
            end
            ok = h1.v && h1.a < CAPW;
            if (armed) begin
                chk("m0_gnt", 32'(m0_gnt), 32'(g.v && !g.p));
                chk("m1_gnt", 32'(m1_gnt), 32'(g.v && g.p));
                chk("mem_we", 32'(mem_we), 32'(ok && h1.we));
                chk("mem_addr", mem_addr, h1.v ? h1.a : 32'd0);
                chk("mem_wd", mem_wd, h1.v ? h1.wd : 32'd0);
                chk("m0_rvalid", 32'(m0_rvalid), 32'(h2.v && !h2.p));
                chk("m1_rvalid", 32'(m1_rvalid), 32'(h2.v && h2.p));
                if (h2.v) begin
                    chk("rdata", h2.p ? m1_rdata : m0_rdata, h2.rd);
                    chk("err", 32'(h2.p ? m1_err : m0_err), 32'(h2.a >= CAPW));
                    chk("other_rdata", h2.p ? m0_rdata : m1_rdata, 32'd0);
                    chk("other_err", 32'(h2.p ? m0_err : m1_err), 32'd0);
                end
            end
            if (h1.v) begin
                h1.rd = (ok && !h1.we) ? ref_mem[h1.a[6:0]] : 32'd0;
                if (ok && h1.we) ref_mem[h1.a[6:0]] = h1.wd;
            end
            if (!rst_n) begin
                h1 = '0;
                h2 = '0;
                lw = 1;
                armed = 1;
            end else begin
                h2 = h1;
                h1 = g;
                if (g.v) lw = g.p;
            end
        end
    end

    // One complete transaction on one port; returns wait cycles before
    // grant, grant/response cycles, response data/err and mem_we seen in
    // the access cycle.
    task automatic xfer(input bit p, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, output int wt, output int gc,
                        output int rc, output logic [31:0] rd,
                        output logic er, output logic mw);
        gc = -1;
        rc = -1;
        wt = 0;
        rd = '0;
        er = 1'b0;
        mw = 1'b0;
        @(negedge clk);
        if (p) begin
            m1_req = 1; m1_we = we; m1_addr = a; m1_wd = wd;
        end else begin
            m0_req = 1; m0_we = we; m0_addr = a; m0_wd = wd;
        end
        for (int k = 0; k < 12 && gc < 0; k++) begin
            #3;
            if (p ? m1_gnt : m0_gnt) begin
                gc = cyc;
                wt = k;
            end
            @(negedge clk);
        end
        m0_req = 0;
        m1_req = 0;
        if (gc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_gnt_timeout: port %0d addr %h", p, a);
            return;
        end
        #3;
        mw = mem_we;
        for (int k = 0; k < 6 && rc < 0; k++) begin
            if (p ? m1_rvalid : m0_rvalid) begin
                rc = cyc;
                rd = p ? m1_rdata : m0_rdata;
                er = p ? m1_err : m0_err;
            end else begin
                @(negedge clk);
                #3;
            end
        end
        if (rc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_rvalid_timeout: port %0d addr %h", p, a);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return $urandom;
        if (r == 1) return CAPW + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 15));
    endfunction

    initial begin : stim
        int wt, gc, rc;
        logic [31:0] rd;
        logic er, mw;
        logic [7:0] g0, g1;
        int ng, nr;
        int gcs [2];
        int rcs [2];
        logic [31:0] rds [2];
        bit tk0, tk1;

        repeat (2) @(negedge clk);
        #3;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1;

        xfer(0, 1, 32'd5, 32'hDEADBEEF, wt, gc, rc, rd, er, mw);
        chk("w5_gnt_wait", 32'(wt), 32'd0);
        chk("w5_mem_we", 32'(mw), 32'd1);
        chk("w5_latency", 32'(rc - gc), 32'd2);
        chk("w5_err", 32'(er), 32'd0);
        xfer(1, 0, 32'd5, 32'd0, wt, gc, rc, rd, er, mw);
        chk("r5_data", rd, 32'hDEADBEEF);
        xfer(1, 1, 32'd128, 32'h1234, wt, gc, rc, rd, er, mw);
        chk("oor_mem_we", 32'(mw), 32'd0);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        xfer(0, 0, 32'd0, 32'd0, wt, gc, rc, rd, er, mw);
        chk("r0_data", rd, 32'd0);
        xfer(1, 0, 32'd1, 32'd0, wt, gc, rc, rd, er, mw);
        chk("r1_data", rd, 32'd0);

        // Continuous contention; last winner is port 1 at this point.
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'd1;
        m1_req = 1; m1_we = 0; m1_addr = 32'd2;
        g0 = '0;
        g1 = '0;
        for (int k = 0; k < 8; k++) begin
            #3;
            g0[k] = m0_gnt;
            g1[k] = m1_gnt;
            @(negedge clk);
        end
        m0_req = 0;
        m1_req = 0;
`ifdef DMEM_ARB_RR_EN
        chk("cont_g0", 32'(g0), 32'h11);
        chk("cont_g1", 32'(g1), 32'h44);
`else
        chk("cont_g0", 32'(g0), 32'h55);
        chk("cont_g1", 32'(g1), 32'h00);
`endif
        repeat (3) @(negedge clk);

        xfer(0, 1, 32'd3, 32'h33333333, wt, gc, rc, rd, er, mw);
        xfer(0, 1, 32'd4, 32'h44444444, wt, gc, rc, rd, er, mw);

        // Back-to-back reads with req held.
        ng = 0;
        nr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m0_req = (ng < 2);
            m0_we = 0;
            m0_addr = (ng == 0) ? 32'd3 : 32'd4;
            #3;
            if (m0_gnt && ng < 2) begin
                gcs[ng] = cyc;
                ng++;
            end
            if (m0_rvalid && nr < 2) begin
                rcs[nr] = cyc;
                rds[nr] = m0_rdata;
                nr++;
            end
        end
        m0_req = 0;
        chk("b2b_ngnt", 32'(ng), 32'd2);
        chk("b2b_nrv", 32'(nr), 32'd2);
        if (ng == 2 && nr == 2) begin
            chk("b2b_gnt_gap", 32'(gcs[1] - gcs[0]), 32'd2);
            chk("b2b_rv_gap", 32'(rcs[1] - rcs[0]), 32'd2);
            chk("b2b_lat", 32'(rcs[0] - gcs[0]), 32'd2);
            chk("b2b_d3", rds[0], 32'h33333333);
            chk("b2b_d4", rds[1], 32'h44444444);
        end

        // Reset during the ACCESS cycle of a write.
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 32'd7; m0_wd = 32'hA5A5A5A5;
        #3;
        chk("ra_gnt", 32'(m0_gnt), 32'd1);
        @(negedge clk);
        m0_req = 0;
        rst_n = 0;
        #3;
        chk("ra_mem_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        rst_n = 1;
        #3;
        chk("ra_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("ra_mem_addr", mem_addr, 32'd0);
        chk("ra_m0_rdata", m0_rdata, 32'd0);
        @(negedge clk);
        #3;
        chk("ra_rvalid2", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        xfer(0, 0, 32'd7, 32'd0, wt, gc, rc, rd, er, mw);
        chk("ra_r7", rd, 32'hA5A5A5A5);

        // Random traffic, occasional resets.
        tk0 = 0;
        tk1 = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            if (tk0 || !m0_req) begin
                m0_req = ($urandom_range(0, 2) != 0);
                m0_we = 1'($urandom);
                m0_addr = rnd_addr();
                m0_wd = $urandom;
            end
            if (tk1 || !m1_req) begin
                m1_req = ($urandom_range(0, 2) != 0);
                m1_we = 1'($urandom);
                m1_addr = rnd_addr();
                m1_wd = $urandom;
            end
            #3;
            tk0 = m0_gnt;
            tk1 = m1_gnt;
        end
        @(negedge clk);
        rst_n = 1;
        m0_req = 0;
        m1_req = 0;
        repeat (4) @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port `data_mem`. It lets the CPU data port (port 0) and the firmware loader/debug port (port 1) share the memory. Each port issues one word request at a time with a req/gnt handshake. The arbiter registers the winning command, drives the memory for exactly one access cycle, and returns read data with a one-cycle `rvalid` pulse. It sits between the core's load/store path and `data_mem`, and owns every `data_mem` input.

## Interface
Parameters:
- `CAPACITY`, 128: memory depth in 32-bit words. Must match `data_mem` `capacity`.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `m0_req`, `m1_req`, in, 1: request valid. Held together with the command until `gnt`.
- `m0_we`, `m1_we`, in, 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`, in, 32: word address (word index, not byte address).
- `m0_wd`, `m1_wd`, in, 32: write data.
- `m0_gnt`, `m1_gnt`, out, 1: command accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`, out, 1: response pulse, registered. Issued for both reads and writes.
- `m0_rdata`, `m1_rdata`, out, 32: read data, valid only while `rvalid` is high. 0 for writes.
- `m0_err`, `m1_err`, out, 1: address out of range, valid with `rvalid`.
- `mem_we`, out, 1: to `data_mem.we`.
- `mem_addr`, out, 32: to `data_mem.addr`.
- `mem_wd`, out, 32: to `data_mem.wd`.
- `mem_rd`, in, 32: from `data_mem.rd` (combinational read).

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any `req` is high, arbitrate. Assert `gnt` to the winner, latch `we`/`addr`/`wd`/port id into command registers, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive `mem_addr` = cmd_addr and `mem_wd` = cmd_wd.
    - In range, write: `mem_we` = cmd_we, so the write commits on the edge that leaves ACCESS.
    - In range, read: `mem_rd` is latched into the rdata register.
    - Always go to RESP.
  - RESP: pulse `rvalid` for the latched port, with `rdata` and `err`. Arbitration also runs here, exactly as in IDLE. A new grant goes to ACCESS; no request goes to IDLE.
- Range check: cmd_addr >= CAPACITY means
  - `mem_we` is forced to 0 and `rdata` = 0;
  - `err` = 1 with the response;
  - the memory is never written.
- Outside ACCESS, `mem_we`, `mem_addr` and `mem_wd` are all 0.
- Only one `gnt` is high per cycle. A losing requester keeps `req` asserted and is served later.
- `rvalid`, `rdata` and `err` of the non-addressed port stay 0.
- Last-winner register: updated on every grant. Reset value is 1, so port 0 wins the first contention.

## Timing
- Reset values:
  - state = IDLE;
  - all `gnt` = 0, all `rvalid` = 0, all `rdata` = 0, all `err` = 0;
  - `mem_we`, `mem_addr`, `mem_wd` = 0;
  - last-winner = 1.
- Latency: `req` seen in cycle N (IDLE) gives `gnt` in N, the memory access in N+1, and `rvalid` in N+2.
- Sustained throughput: one access every 2 cycles (RESP overlaps the next grant).
- Simultaneous requests: arbitration policy per Configuration.
- A request arriving during ACCESS is not granted until the following RESP cycle.
- Reset mid-operation: `rst_n` low on any edge forces IDLE and all outputs to reset values, and no `rvalid` is issued.
  - If the reset edge coincides with the end of an ACCESS write, that write still commits, because `mem_we` is decoded from the pre-edge state.
- No combinational path from `mem_rd` to any output.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On contention, the port that did not win last gets `gnt`.
- Undefined: fixed priority. Port 0 always wins contention, and port 1 is served only when `m0_req` = 0 at the arbitration cycle.
- The last-winner register exists in both builds. It is unused when the macro is undefined.

## Test plan
- Reset, then a single port 0 write of addr 5, wd 0xDEADBEEF:
  - `m0_gnt` in cycle 0, `mem_we` = 1 in cycle 1, `m0_rvalid` in cycle 2 with `err` = 0;
  - a subsequent port 1 read of addr 5 returns `m1_rdata` = 0xDEADBEEF.
- Out of range: port 1 write of addr 128, wd 0x1234:
  - `mem_we` stays 0;
  - `m1_rvalid` with `m1_err` = 1 and `m1_rdata` = 0;
  - a port 0 read of addr 0 shows the previous contents unchanged.
- Both ports request continuously with reads of addr 1 and addr 2:
  - RR build: grants alternate 0,1,0,1 at 2-cycle spacing;
  - non-RR build: port 0 is granted every grant slot and port 1 never.
- Back-to-back port 0 reads of addr 3, then addr 4, with `req` held:
  - `gnt` pulses 2 cycles apart;
  - `rvalid` pulses 2 cycles apart, with the correct data for each.
- `rst_n` low during the ACCESS cycle of a write of 0xA5A5A5A5 to addr 7:
  - no `rvalid` is issued and outputs are at reset values the next cycle;
  - a later read of addr 7 returns 0xA5A5A5A5.
